exin_axil_regbank: RTL and testbench

Parametrised AXI4-Lite slave register bank for Exin accelerator cores. It generalises the fixed four-register slave to a configurable register count and data width. It adds byte-strobe writes, read-only status registers fed by the core, per-register write strobes and SLVERR decoding. It sits between the AXI interconnect (VIP master in simulation) and the compute datapath.

---
 rtl/exin_axil_regbank_if.sv | 52 +++++
 rtl/exin_axil_regbank.sv | 171 +++++++++++++++++
 tb/tb_exin_axil_regbank.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exin_axil_regbank_if.sv
// AXI4-Lite bus bundle for the Exin register bank: one slave view for the bank,
// one master view for the interconnect or a simulation driver.
interface exin_axil_regbank_if #(
    parameter int DW = 32,
    parameter int AW = 6
);
    logic [AW-1:0]   S_AXI_AWADDR;
    logic [2:0]      S_AXI_AWPROT;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;
    logic [DW-1:0]   S_AXI_WDATA;
    logic [DW/8-1:0] S_AXI_WSTRB;
    logic            S_AXI_WVALID;
    logic            S_AXI_WREADY;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;
    logic [AW-1:0]   S_AXI_ARADDR;
    logic [2:0]      S_AXI_ARPROT;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;
    logic [DW-1:0]   S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/exin_axil_regbank.sv
// Parametrised AXI4-Lite register bank: byte-strobed RW registers, RO status
// slots fed from the core, per-register write pulses and SLVERR decoding.
module exin_axil_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_NUM_REGS         = 16,
    parameter logic [C_NUM_REGS-1:0] C_RO_MASK = '0
) (
    input  logic ACLK,
    input  logic ARESET,
    exin_axil_regbank_if.slave s_axi,
    output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] sts_in,
    output logic [C_NUM_REGS-1:0] wr_pulse
);
    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int N        = C_NUM_REGS;
    localparam int NB       = DW / 8;
    localparam int ADDR_LSB = $clog2(NB);
    localparam int IW       = AW - ADDR_LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic          ready_en;
    logic          aw_full;
    logic          w_full;
    logic [IW-1:0] aw_idx;
    logic [DW-1:0] w_data;
    logic [NB-1:0] w_strb;
    logic          b_valid;
    logic [1:0]    b_resp;
    logic          r_valid;
    logic [1:0]    r_resp;
    logic [DW-1:0] r_data;
    logic [N-1:0]  pulse_pend;
    logic [DW-1:0] regs [N];

    logic          aw_hs;
    logic          w_hs;
    logic          ar_hs;
    logic          commit;
    logic [IW-1:0] ar_idx;
    logic [N-1:0]  wr_sel;
    logic          wr_err;
    logic [DW-1:0] rd_data;
    logic          rd_err;

    // Handshakes: a transfer happens on a rising edge where VALID and READY are
    // both high; a source holds VALID and its payload until that edge, and the
    // READYs here depend only on registered state, never on an incoming VALID.
    assign s_axi.S_AXI_AWREADY = ready_en & ~aw_full & ~b_valid;
    assign s_axi.S_AXI_WREADY  = ready_en & ~w_full & ~b_valid;
    assign s_axi.S_AXI_ARREADY = ready_en & ~r_valid;
    assign s_axi.S_AXI_BVALID  = b_valid;
    assign s_axi.S_AXI_BRESP   = b_resp;
    assign s_axi.S_AXI_RVALID  = r_valid;
    assign s_axi.S_AXI_RRESP   = r_resp;
    assign s_axi.S_AXI_RDATA   = r_data;

    assign aw_hs  = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
    assign w_hs   = s_axi.S_AXI_WVALID & s_axi.S_AXI_WREADY;
    assign ar_hs  = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;
    assign commit = aw_full & w_full & ~b_valid;
    assign ar_idx = s_axi.S_AXI_ARADDR[AW-1:ADDR_LSB];

    // Out-of-range and read-only targets leave wr_sel empty and raise wr_err.
    always_comb begin
        wr_sel = '0;
        wr_err = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (int'(aw_idx) == i) begin
                wr_err    = C_RO_MASK[i];
                wr_sel[i] = ~C_RO_MASK[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (int'(ar_idx) == i) begin
                rd_err  = 1'b0;
                rd_data = C_RO_MASK[i] ? sts_in[i*DW +: DW] : regs[i];
            end
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < N; i++) begin
            reg_out[i*DW +: DW] = C_RO_MASK[i] ? '0 : regs[i];
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ready_en   <= 1'b0;
            aw_full    <= 1'b0;
            w_full     <= 1'b0;
            aw_idx     <= '0;
            w_data     <= '0;
            w_strb     <= '0;
            b_valid    <= 1'b0;
            b_resp     <= RESP_OKAY;
            pulse_pend <= '0;
            wr_pulse   <= '0;
        end else begin
            ready_en   <= 1'b1;
            pulse_pend <= '0;
            wr_pulse   <= pulse_pend;
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= s_axi.S_AXI_AWADDR[AW-1:ADDR_LSB];
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= s_axi.S_AXI_WDATA;
                w_strb <= s_axi.S_AXI_WSTRB;
            end
            if (commit) begin
                aw_full    <= 1'b0;
                w_full     <= 1'b0;
                b_valid    <= 1'b1;
                b_resp     <= wr_err ? RESP_SLVERR : RESP_OKAY;
                pulse_pend <= wr_sel;
            end else if (b_valid && s_axi.S_AXI_BREADY) begin
                b_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < N; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < N; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_sel[i] && w_strb[b]) begin
                        regs[i][8*b +: 8] <= w_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Reads sample regs before any same-edge commit lands, so a colliding read
    // returns the old value.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_valid <= 1'b0;
            r_resp  <= RESP_OKAY;
            r_data  <= '0;
        end else if (ar_hs) begin
            r_valid <= 1'b1;
            r_resp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            r_data  <= rd_data;
        end else if (r_valid && s_axi.S_AXI_RREADY) begin
            r_valid <= 1'b0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[ADDR_LSB-1:0],
                           s_axi.S_AXI_ARADDR[ADDR_LSB-1:0], sts_in};
endmodule

// File: tb/tb_exin_axil_regbank.sv
// Bench for exin_axil_regbank: directed vector table, hand-timed corner
// sequences, then random traffic against a register-array reference model.
module tb_exin_axil_regbank;
    localparam int DW = 32;
    localparam int AW = 7;
    localparam int N  = 16;
    localparam int NB = DW / 8;
    localparam logic [N-1:0] RO_MASK = 16'h0020;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exin_axil_regbank_if #(.DW(DW), .AW(AW)) bus ();
    logic [N*DW-1:0] reg_out;
    logic [N*DW-1:0] sts_in;
    logic [N-1:0]    wr_pulse;

    exin_axil_regbank #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_NUM_REGS(N),
        .C_RO_MASK(RO_MASK)
    ) dut (
        .ACLK(clk),
        .ARESET(rst),
        .s_axi(bus),
        .reg_out(reg_out),
        .sts_in(sts_in),
        .wr_pulse(wr_pulse)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];
    int pulse_cnt [N];

    initial begin
        for (int i = 0; i < N; i++) pulse_cnt[i] = 0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (wr_pulse[i] === 1'b1) pulse_cnt[i] = pulse_cnt[i] + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [NB-1:0] s, input int bdelay,
                             output logic [1:0] resp);
        int cyc;
        int held;
        bit b_done;
        logic aw_hs, w_hs, b_hs;
        cyc = 0; held = 0; b_done = 0; resp = 2'b11;
        @(negedge clk);
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = (bdelay == 0);
        while (!b_done && cyc < 60) begin
            aw_hs = bus.S_AXI_AWVALID & bus.S_AXI_AWREADY;
            w_hs  = bus.S_AXI_WVALID & bus.S_AXI_WREADY;
            b_hs  = bus.S_AXI_BVALID & bus.S_AXI_BREADY;
            if (b_hs) begin
                resp   = bus.S_AXI_BRESP;
                b_done = 1;
            end
            @(negedge clk);
            if (aw_hs) bus.S_AXI_AWVALID = 1'b0;
            if (w_hs)  bus.S_AXI_WVALID  = 1'b0;
            if (b_hs) begin
                bus.S_AXI_BREADY = 1'b0;
            end else if (bus.S_AXI_BVALID) begin
                held++;
                bus.S_AXI_BREADY = (held >= bdelay);
            end
            cyc++;
        end
        if (!b_done) begin
            n_tests++;
            n_fail++;
            $display("FAIL write_timeout addr %0h: no B response in 60 cycles, required one", a);
            bus.S_AXI_AWVALID = 1'b0;
            bus.S_AXI_WVALID  = 1'b0;
            bus.S_AXI_BREADY  = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                            output logic [1:0] resp);
        int cyc;
        bit r_done;
        logic ar_hs, r_hs;
        cyc = 0; r_done = 0; d = '0; resp = 2'b11;
        @(negedge clk);
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b1;
        while (!r_done && cyc < 60) begin
            ar_hs = bus.S_AXI_ARVALID & bus.S_AXI_ARREADY;
            r_hs  = bus.S_AXI_RVALID & bus.S_AXI_RREADY;
            if (r_hs) begin
                d      = bus.S_AXI_RDATA;
                resp   = bus.S_AXI_RRESP;
                r_done = 1;
            end
            @(negedge clk);
            if (ar_hs) bus.S_AXI_ARVALID = 1'b0;
            if (r_hs)  bus.S_AXI_RREADY  = 1'b0;
            cyc++;
        end
        if (!r_done) begin
            n_tests++;
            n_fail++;
            $display("FAIL read_timeout addr %0h: no R response in 60 cycles, required one", a);
            bus.S_AXI_ARVALID = 1'b0;
            bus.S_AXI_RREADY  = 1'b0;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [NB-1:0] strb;
        logic [1:0]    exp_resp;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t tbl [18];

    // ---------------- reference model for random phase ----------------
    logic [DW-1:0] model [N];
    int exp_pulse [N];
    int base_cnt  [N];

    initial begin
        logic [1:0]    resp;
        logic [DW-1:0] rd;
        int            idx;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [NB-1:0] s;
        logic [1:0]    exp_resp;
        logic [DW-1:0] exp_d;

        tbl[0]  = '{1'b1, 7'h00, 32'h0000_0001, 4'hF, 2'b00, 32'h0};
        tbl[1]  = '{1'b1, 7'h04, 32'h0000_0002, 4'hF, 2'b00, 32'h0};
        tbl[2]  = '{1'b1, 7'h08, 32'h0000_0003, 4'hF, 2'b00, 32'h0};
        tbl[3]  = '{1'b1, 7'h0C, 32'h0000_0004, 4'hF, 2'b00, 32'h0};
        tbl[4]  = '{1'b0, 7'h00, 32'h0, 4'h0, 2'b00, 32'h0000_0001};
        tbl[5]  = '{1'b0, 7'h04, 32'h0, 4'h0, 2'b00, 32'h0000_0002};
        tbl[6]  = '{1'b0, 7'h08, 32'h0, 4'h0, 2'b00, 32'h0000_0003};
        tbl[7]  = '{1'b0, 7'h0C, 32'h0, 4'h0, 2'b00, 32'h0000_0004};
        tbl[8]  = '{1'b1, 7'h10, 32'hAABB_CCDD, 4'hF, 2'b00, 32'h0};
        tbl[9]  = '{1'b1, 7'h10, 32'h1122_3344, 4'h5, 2'b00, 32'h0};
        tbl[10] = '{1'b0, 7'h10, 32'h0, 4'h0, 2'b00, 32'hAA22_CC44};
        tbl[11] = '{1'b0, 7'h14, 32'h0, 4'h0, 2'b00, 32'hDEAD_BEEF};
        tbl[12] = '{1'b1, 7'h14, 32'h1234_5678, 4'hF, 2'b10, 32'h0};
        tbl[13] = '{1'b0, 7'h14, 32'h0, 4'h0, 2'b00, 32'hDEAD_BEEF};
        tbl[14] = '{1'b0, 7'h40, 32'h0, 4'h0, 2'b10, 32'h0};
        tbl[15] = '{1'b1, 7'h40, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0};
        tbl[16] = '{1'b0, 7'h7C, 32'h0, 4'h0, 2'b10, 32'h0};
        tbl[17] = '{1'b0, 7'h3C, 32'h0, 4'h0, 2'b00, 32'h0};

        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        for (int i = 0; i < N; i++) sts_in[i*DW +: DW] = $urandom();
        sts_in[0*DW +: DW] = 32'hBAD0_BAD0;
        sts_in[5*DW +: DW] = 32'hDEAD_BEEF;

        // ---- reset values and ready release timing ----
        repeat (3) @(negedge clk);
        check("rst_awready", 64'(bus.S_AXI_AWREADY), 0);
        check("rst_wready",  64'(bus.S_AXI_WREADY), 0);
        check("rst_arready", 64'(bus.S_AXI_ARREADY), 0);
        check("rst_bvalid",  64'(bus.S_AXI_BVALID), 0);
        check("rst_rvalid",  64'(bus.S_AXI_RVALID), 0);
        check("rst_rdata",   64'(bus.S_AXI_RDATA), 0);
        check("rst_wr_pulse", 64'(wr_pulse), 0);
        check("rst_reg_out_or", 64'(|reg_out), 0);
        rst = 1'b0;
        check("rel_arready_same_cycle", 64'(bus.S_AXI_ARREADY), 0);
        @(negedge clk);
        check("rel_awready", 64'(bus.S_AXI_AWREADY), 1);
        check("rel_wready",  64'(bus.S_AXI_WREADY), 1);
        check("rel_arready", 64'(bus.S_AXI_ARREADY), 1);

        // ---- directed vector table ----
        for (int i = 0; i < N; i++) base_cnt[i] = pulse_cnt[i];
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].is_wr) begin
                axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, resp);
                check($sformatf("tbl%0d_bresp", i), 64'(resp), 64'(tbl[i].exp_resp));
            end else begin
                axi_read(tbl[i].addr, rd, resp);
                check($sformatf("tbl%0d_rdata", i), 64'(rd), 64'(tbl[i].exp_data));
                check($sformatf("tbl%0d_rresp", i), 64'(resp), 64'(tbl[i].exp_resp));
            end
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("tbl_pulses_r%0d", i), 64'(pulse_cnt[i] - base_cnt[i]),
                  (i < 4) ? 64'd1 : (i == 4) ? 64'd2 : 64'd0);
        end
        check("tbl_ro_slot_reg_out", 64'(reg_out[5*DW +: DW]), 0);

        // ---- W three cycles ahead of AW, BREADY held low five cycles ----
        @(negedge clk);
        bus.S_AXI_WDATA = 32'h0000_0077; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b0;
        check("ord_wready_idle", 64'(bus.S_AXI_WREADY), 1);
        @(negedge clk);
        bus.S_AXI_WVALID = 1'b0;
        check("ord_wready_full", 64'(bus.S_AXI_WREADY), 0);
        @(negedge clk);
        check("ord_no_commit_w_only", 64'(bus.S_AXI_BVALID), 0);
        @(negedge clk);
        bus.S_AXI_AWADDR = 7'h18; bus.S_AXI_AWVALID = 1'b1;
        check("ord_awready", 64'(bus.S_AXI_AWREADY), 1);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        check("ord_bvalid_before_commit", 64'(bus.S_AXI_BVALID), 0);
        check("ord_awready_full", 64'(bus.S_AXI_AWREADY), 0);
        @(negedge clk);
        check("ord_reg6_committed", 64'(reg_out[6*DW +: DW]), 64'h77);
        check("ord_bresp", 64'(bus.S_AXI_BRESP), 0);
        check("ord_pulse_not_yet", 64'(wr_pulse), 0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("ord_bvalid_hold%0d", k), 64'(bus.S_AXI_BVALID), 1);
            check($sformatf("ord_awready_blk%0d", k), 64'(bus.S_AXI_AWREADY), 0);
            check($sformatf("ord_wready_blk%0d", k), 64'(bus.S_AXI_WREADY), 0);
            if (k == 1) check("ord_wr_pulse", 64'(wr_pulse), 64'h0040);
            if (k == 2) check("ord_wr_pulse_end", 64'(wr_pulse), 0);
        end
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        check("ord_bvalid_cleared", 64'(bus.S_AXI_BVALID), 0);
        check("ord_awready_back", 64'(bus.S_AXI_AWREADY), 1);
        check("ord_wready_back", 64'(bus.S_AXI_WREADY), 1);

        // ---- same-edge commit and read of register 2 ----
        @(negedge clk);
        bus.S_AXI_AWADDR = 7'h08; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h55; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_ARADDR = 7'h08; bus.S_AXI_ARVALID = 1'b1;
        check("col_arready", 64'(bus.S_AXI_ARREADY), 1);
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        check("col_rvalid", 64'(bus.S_AXI_RVALID), 1);
        check("col_rdata_old", 64'(bus.S_AXI_RDATA), 64'h3);
        check("col_bvalid", 64'(bus.S_AXI_BVALID), 1);
        check("col_reg2_new", 64'(reg_out[2*DW +: DW]), 64'h55);
        bus.S_AXI_RREADY = 1'b1; bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;
        check("col_rvalid_cleared", 64'(bus.S_AXI_RVALID), 0);
        check("col_arready_back", 64'(bus.S_AXI_ARREADY), 1);
        axi_read(7'h08, rd, resp);
        check("col_reread", 64'(rd), 64'h55);

        // ---- reset with B and R both pending ----
        @(negedge clk);
        bus.S_AXI_AWADDR = 7'h1C; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'hCAFE; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_ARADDR = 7'h04; bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        @(negedge clk);
        check("mrst_bvalid_pre", 64'(bus.S_AXI_BVALID), 1);
        check("mrst_rvalid_pre", 64'(bus.S_AXI_RVALID), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_bvalid", 64'(bus.S_AXI_BVALID), 0);
        check("mrst_rvalid", 64'(bus.S_AXI_RVALID), 0);
        check("mrst_awready", 64'(bus.S_AXI_AWREADY), 0);
        check("mrst_arready", 64'(bus.S_AXI_ARREADY), 0);
        check("mrst_reg_out", 64'(|reg_out), 0);
        check("mrst_rdata", 64'(bus.S_AXI_RDATA), 0);
        rst = 1'b0;
        check("mrst_wready_at_release", 64'(bus.S_AXI_WREADY), 0);
        @(negedge clk);
        check("mrst_awready_up", 64'(bus.S_AXI_AWREADY), 1);
        check("mrst_wready_up", 64'(bus.S_AXI_WREADY), 1);
        check("mrst_arready_up", 64'(bus.S_AXI_ARREADY), 1);
        check("mrst_no_stale_b", 64'(bus.S_AXI_BVALID), 0);
        for (int i = 0; i < N; i++) begin
            if (!RO_MASK[i]) begin
                axi_read(AW'(i * 4), rd, resp);
                check($sformatf("mrst_read_r%0d", i), 64'(rd), 0);
            end
        end

        // ---- random traffic against the model ----
        for (int i = 0; i < N; i++) begin
            model[i] = '0;
            exp_pulse[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) base_cnt[i] = pulse_cnt[i];
        for (int k = 0; k < 160; k++) begin
            idx = $urandom_range(0, 19);
            a = AW'(idx * 4 + $urandom_range(0, 3));
            sts_in[5*DW +: DW] = $urandom();
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom();
                s = NB'($urandom_range(0, 15));
                if (idx >= N || RO_MASK[idx]) begin
                    exp_resp = 2'b10;
                end else begin
                    exp_resp = 2'b00;
                    for (int b = 0; b < NB; b++) begin
                        if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
                    end
                    exp_pulse[idx]++;
                end
                axi_write(a, d, s, $urandom_range(0, 3), resp);
                check($sformatf("rnd%0d_bresp", k), 64'(resp), 64'(exp_resp));
            end else begin
                if (idx >= N) begin
                    exp_d = '0; exp_resp = 2'b10;
                end else if (RO_MASK[idx]) begin
                    exp_d = sts_in[idx*DW +: DW]; exp_resp = 2'b00;
                end else begin
                    exp_d = model[idx]; exp_resp = 2'b00;
                end
                exp_q.push_back(exp_d);
                axi_read(a, rd, resp);
                check($sformatf("rnd%0d_rdata", k), 64'(rd), 64'(exp_q.pop_front()));
                check($sformatf("rnd%0d_rresp", k), 64'(resp), 64'(exp_resp));
            end
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("rnd_pulses_r%0d", i), 64'(pulse_cnt[i] - base_cnt[i]), 64'(exp_pulse[i]));
            check($sformatf("rnd_reg_out_r%0d", i), 64'(reg_out[i*DW +: DW]),
                  RO_MASK[i] ? 64'd0 : 64'(model[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
